// File: rtl/path_replay_pkg.sv
`default_nettype none
// ============================================================================
// Module      : path_replay_pkg
// Description : Shared types and helpers for the maze path stack and replay
//               engine: direction codes, start/destination locations, replay
//               FSM states and the one-cell location step.
// Revision    : 1.0 - initial release
// ============================================================================
package path_replay_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    localparam logic [7:0] START_LOC = 8'h00;
    localparam logic [7:0] DEST_LOC  = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EMIT = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    // Move one cell from loc = {row, col}; each nibble wraps mod 16 because
    // the solver only ever issues legal moves.
    function automatic logic [7:0] loc_step(input logic [7:0] loc,
                                            input logic [1:0] dir);
        logic [7:0] nxt;
        nxt = loc;
        case (dir)
            DIR_UP:    nxt = {loc[7:4] - 4'd1, loc[3:0]};
            DIR_RIGHT: nxt = {loc[7:4], loc[3:0] + 4'd1};
            DIR_DOWN:  nxt = {loc[7:4] + 4'd1, loc[3:0]};
            default:   nxt = {loc[7:4], loc[3:0] - 4'd1};
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dir_stack_mem.sv
`default_nettype none
// ============================================================================
// Module      : dir_stack_mem
// Description : DEPTH x 2-bit direction storage with one synchronous write
//               port and one registered read port (1-cycle read latency).
//               Contents are intentionally not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dir_stack_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [1:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [1:0]    rd_data
);

    logic [1:0] mem_q [DEPTH];
    logic [1:0] rd_data_q;

    // Write port and registered read port; the read register only updates
    // when requested so the read data holds steady between loads.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/path_replay.sv
`default_nettype none
// ============================================================================
// Module      : path_replay
// Description : LIFO direction stack written by the maze solver, plus a
//               playback engine that streams the stored path bottom-to-top
//               as (direction, resulting location) beats on a valid/ready
//               interface.
// Revision    : 1.0 - initial release
// ============================================================================
module path_replay
    import path_replay_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [1:0] dirIn,
    output logic       empStck,
    output logic       fullStck,
    input  logic       replayStart,
    input  logic       outReady,
    output logic       outValid,
    output logic [1:0] outDir,
    output logic [7:0] outLoc,
    output logic       busy,
    output logic       replayDone
);

    localparam logic [AW:0] c_one  = (AW+1)'(1);
    localparam logic [AW:0] c_full = (AW+1)'(DEPTH);

    state_t      state_q, state_d;
    logic [AW:0] sp_q, sp_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  curr_loc_q, curr_loc_d;

    logic [AW:0]   sp_m1;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          rd_en;
    logic [1:0]    rd_data;
    logic [7:0]    next_loc;

    assign sp_m1    = sp_q - c_one;
    assign empStck  = (sp_q == '0);
    assign fullStck = (sp_q == c_full);
    assign next_loc = loc_step(curr_loc_q, rd_data);

    dir_stack_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (dirIn),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (rd_data)
    );

    // Solver stack operations; only honoured while the replay engine is idle
    // so the stored path cannot change underneath playback.
    always_comb begin
        sp_d    = sp_q;
        wr_en   = 1'b0;
        wr_addr = sp_q[AW-1:0];
        if (state_q == ST_IDLE) begin
            if (push && pop && !empStck) begin
                wr_en   = 1'b1;
                wr_addr = sp_m1[AW-1:0];
            end else if (push && !fullStck) begin
                wr_en = 1'b1;
                sp_d  = sp_q + c_one;
            end else if (pop && !push && !empStck) begin
                sp_d = sp_m1;
            end
        end
    end

    // Replay FSM: next state, read pointer, running location and beat outputs.
    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        curr_loc_d = curr_loc_q;
        rd_en      = 1'b0;
        outValid   = 1'b0;
        outDir     = 2'd0;
        outLoc     = 8'h00;
        replayDone = 1'b0;
        busy       = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (replayStart) begin
                    curr_loc_d = START_LOC;
                    rd_ptr_d   = '0;
                    state_d    = empStck ? ST_FIN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                rd_en   = 1'b1;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                outValid = 1'b1;
                outDir   = rd_data;
                outLoc   = next_loc;
                if (outReady) begin
                    curr_loc_d = next_loc;
                    rd_ptr_d   = rd_ptr_q + c_one;
                    state_d    = (rd_ptr_q == sp_m1) ? ST_FIN : ST_LOAD;
                end
            end
            default: begin
                replayDone = 1'b1;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State and pointer registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            sp_q       <= '0;
            rd_ptr_q   <= '0;
            curr_loc_q <= START_LOC;
        end else begin
            state_q    <= state_d;
            sp_q       <= sp_d;
            rd_ptr_q   <= rd_ptr_d;
            curr_loc_q <= curr_loc_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/path_replay.md
Name: path_replay

Overview:
- Direction stack for the maze solver, plus a playback engine that reads the stored path back out as a stream of moves.
- During solving it is written LIFO: the solver controller pushes each move direction and pops on backtrack.
- After the solve, playback reads the stack bottom-to-top. Each beat carries the direction and the resulting maze location.
- Downstream consumers (display, path logger) receive these beats over a valid/ready handshake.

Parameters:
DEPTH, 256, number of 2-bit direction entries (one per maze cell)
AW, 8, pointer width; log2(DEPTH)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
push  input  1  solver push request; stores dirIn on top
pop  input  1  solver pop request; discards top entry
dirIn  input  2  direction to push (0 up, 1 right, 2 down, 3 left)
empStck  output  1  stack empty (sp == 0)
fullStck  output  1  stack full (sp == DEPTH)
replayStart  input  1  one-cycle request to begin playback
outReady  input  1  consumer accepts current beat
outValid  output  1  beat valid
outDir  output  2  direction of current move
outLoc  output  8  location after the move, {row[3:0], col[3:0]}
busy  output  1  playback in progress
replayDone  output  1  one-cycle pulse when playback finishes

Behaviour:
- Reset (rst low, asynchronous): sp = 0, rdPtr = 0, currLoc = 8'h00, state IDLE.
  - Output reset values: outValid 0, outDir 0, outLoc 8'h00, busy 0, replayDone 0, empStck 1, fullStck 0.
  - Storage contents are not reset.
- Stack operations are accepted only in IDLE. They take effect on the clock edge:
  - push alone: mem[sp] = dirIn, sp + 1. Ignored if full.
  - pop alone: sp - 1. Ignored if empty.
  - push and pop together: top replaced, mem[sp-1] = dirIn, sp unchanged. If empty, treated as push alone.
- empStck and fullStck are combinational from sp.
- Location arithmetic, with row = loc[7:4] and col = loc[3:0]:
  - up: row - 1
  - right: col + 1
  - down: row + 1
  - left: col - 1
  - Each nibble wraps mod 16. No bounds check; the solver guarantees legal moves.
- State machine: IDLE, LOAD, EMIT, FIN.
  - IDLE: on replayStart, currLoc = 8'h00 and rdPtr = 0.
    - If sp == 0, go to FIN.
    - Otherwise go to LOAD.
  - LOAD: synchronous read of mem[rdPtr] (1-cycle latency). Go to EMIT.
  - EMIT:
    - outValid = 1, outDir = read data, outLoc = currLoc stepped by outDir.
    - outDir and outLoc are held stable while outReady is low.
    - On the handshake (outValid & outReady): currLoc = outLoc and rdPtr + 1.
    - If rdPtr == sp - 1, go to FIN; otherwise go to LOAD.
  - FIN: replayDone = 1 for exactly one cycle, then IDLE.
- Timing: first beat is valid 2 cycles after replayStart. Maximum throughput is one beat per 2 cycles.
- busy = 1 in LOAD, EMIT and FIN.
- While busy, push, pop and replayStart are ignored and sp is frozen.
- Playback is non-destructive: sp is unchanged afterwards, so a second replayStart replays the same path.
- Reset mid-playback returns to IDLE immediately and outValid drops asynchronously.

Decomposition:
- Shared package holds:
  - direction constants DIR_UP=0, DIR_RIGHT=1, DIR_DOWN=2, DIR_LEFT=3
  - START_LOC=8'h00, DEST_LOC=8'hFF
  - the state encodings
  - the loc-step function, which is also used by the solver datapath
- One natural sub-module: dir_stack_mem, a DEPTH x 2 storage with one synchronous write port and one registered read port.

Test Plan:
- Reset checks:
  - Assert rst low mid-EMIT -> outValid 0, busy 0, empStck 1, outLoc 8'h00 immediately.
  - After release, replayStart -> replayDone pulse with no beats.
- Basic playback:
  - push 1, 1, 2, then replayStart, with outReady held 1.
  - Expect beats (1, 8'h01), (1, 8'h02), (2, 8'h12).
  - replayDone one cycle after the third handshake; sp still 3.
- Backtrack:
  - push 2, push 1, pop, push 2, then replay.
  - Expect beats (2, 8'h10), (2, 8'h20).
- Simultaneous push and pop:
  - push 1, then push+pop with dirIn = 2 in the same cycle.
  - Expect sp = 1; replay yields a single beat (2, 8'h10).
- Backpressure:
  - Hold outReady 0 for 5 cycles during the first beat.
  - outDir and outLoc stay stable, rdPtr does not advance; the beat completes when outReady rises.
- Full and wrap:
  - Push 256 entries: fullStck = 1 and the 257th push is ignored.
  - From START_LOC, a left (dir 3) push then replay gives outLoc 8'h0F (column wrap).
  - replayStart while busy has no effect.
